// File: rtl/twobit_frame_loader_pkg.sv
// Shared constants, state encoding and packing helper for the two-bit frame loader
// and the contour mesh it feeds.
package twobit_frame_loader_pkg;
    localparam int COLS    = 26;
    localparam int ROWS    = 18;
    localparam int NPIX    = COLS * ROWS;
    localparam int PIXW    = 2;
    localparam int FRAME_W = PIXW * NPIX;
    localparam int IDX_W   = 9;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Raster pixel 0 lands in the top bits of the frame vector, pixel NPIX-1 in the bottom.
    function automatic logic [9:0] pix_slice_lsb(input logic [IDX_W-1:0] p);
        return 10'(PIXW * (NPIX - 1 - int'(p)));
    endfunction
endpackage

// File: rtl/twobit_frame_loader_if.sv
// Pixel stream in, packed frame out. master = stream source / frame consumer, slave = loader.
interface twobit_frame_loader_if;
    import twobit_frame_loader_pkg::*;

    logic [7:0]         pix_in;
    logic               pix_sof;
    logic               pix_valid;
    logic               pix_ready;
    logic [FRAME_W-1:0] frame;
    logic               frame_valid;
    logic               frame_ready;
    logic [7:0]         frame_count;
    logic               sof_err;

    modport master (
        output pix_in, pix_sof, pix_valid, frame_ready,
        input  pix_ready, frame, frame_valid, frame_count, sof_err
    );

    modport slave (
        input  pix_in, pix_sof, pix_valid, frame_ready,
        output pix_ready, frame, frame_valid, frame_count, sof_err
    );
endinterface

// File: rtl/twobit_frame_loader_quantizer.sv
// Combinational 8-bit grayscale to 2-bit level quantizer using three unsigned thresholds.
module twobit_quantizer #(
    parameter logic [7:0] TH1 = 8'd64,
    parameter logic [7:0] TH2 = 8'd128,
    parameter logic [7:0] TH3 = 8'd192
) (
    input  logic [7:0] pix,
    output logic [1:0] q
);
    always_comb begin
        if (pix < TH1)      q = 2'd0;
        else if (pix < TH2) q = 2'd1;
        else if (pix < TH3) q = 2'd2;
        else                q = 2'd3;
    end
endmodule

// File: rtl/twobit_frame_loader.sv
// Double-buffered raster loader: quantizes the pixel stream into a back buffer and
// swaps completed frames into the front buffer that drives the mesh.
module twobit_frame_loader
    import twobit_frame_loader_pkg::*;
#(
    parameter logic [7:0] TH1         = 8'd64,
    parameter logic [7:0] TH2         = 8'd128,
    parameter logic [7:0] TH3         = 8'd192,
    parameter bit         REQUIRE_SOF = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    twobit_frame_loader_if.slave  bus
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [FRAME_W-1:0] back_q, back_d;
    logic [FRAME_W-1:0] front_q, front_d;
    logic               fv_q, fv_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               err_q, err_d;

    logic [1:0]       q;
    logic             ready;
    logic             accept, consume, drop, wr, last, swap;
    logic [IDX_W-1:0] wr_idx;

    twobit_quantizer #(.TH1(TH1), .TH2(TH2), .TH3(TH3)) u_quant (
        .pix (bus.pix_in),
        .q   (q)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= FILL;
        else     state_q <= state_d;
    end

    // Datapath decode shared by the next-state and register logic
    always_comb begin
        accept  = bus.pix_valid & ready;
        consume = fv_q & bus.frame_ready;
        drop    = accept & REQUIRE_SOF & ~bus.pix_sof & (idx_q == '0);
        wr      = accept & ~drop;
        // An SOF always restarts the frame at raster index 0.
        wr_idx  = bus.pix_sof ? '0 : idx_q;
        last    = wr & (wr_idx == LAST_IDX);
    end

    // Next-state
    always_comb begin
        state_d = state_q;
        swap    = 1'b0;
        case (state_q)
            FILL: begin
                if (last) begin
                    if (!fv_q || bus.frame_ready) swap    = 1'b1;
                    else                          state_d = HOLD;
                end
            end
            HOLD: begin
                if (consume) begin
                    swap    = 1'b1;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Outputs
    always_comb begin
        ready           = (state_q == FILL);
        bus.pix_ready   = ready;
        bus.frame       = front_q;
        bus.frame_valid = fv_q;
        bus.frame_count = cnt_q;
        bus.sof_err     = err_q;
    end

    // Buffer and counter next values
    always_comb begin
        back_d = back_q;
        idx_d  = idx_q;
        if (wr) begin
            back_d[pix_slice_lsb(wr_idx) +: PIXW] = q;
            idx_d = last ? '0 : wr_idx + IDX_W'(1);
        end
        // The last pixel goes straight through to the front buffer in the swap cycle.
        front_d = swap ? back_d : front_q;
        if (swap)         fv_d = 1'b1;
        else if (consume) fv_d = 1'b0;
        else              fv_d = fv_q;
        cnt_d = swap ? cnt_q + 8'd1 : cnt_q;
        err_d = drop | (accept & bus.pix_sof & (idx_q != '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            back_q  <= '0;
            front_q <= '0;
            fv_q    <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            back_q  <= back_d;
            front_q <= front_d;
            fv_q    <= fv_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_twobit_frame_loader.sv
// Directed bench for twobit_frame_loader: streams full frames and checks the packed front buffer.
module tb_twobit_frame_loader;
    import twobit_frame_loader_pkg::*;

    typedef struct {
        logic [7:0] pix;
        logic [1:0] q;
    } thr_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [7:0] vals[NPIX];
    logic [1:0] exp_q[NPIX];
    thr_vec_t   tv[7];

    twobit_frame_loader_if bus ();

    twobit_frame_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] qref(input int v);
        if (v < 64)  return 2'd0;
        if (v < 128) return 2'd1;
        if (v < 192) return 2'd2;
        return 2'd3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic chk_frame(input string name);
        int bad = -1;
        n_checks++;
        for (int p = 0; p < NPIX; p++)
            if (bad < 0 && bus.frame[2*(NPIX-1-p) +: 2] !== exp_q[p]) bad = p;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s: pixel %0d got %0d expected %0d", name, bad,
                     bus.frame[2*(NPIX-1-bad) +: 2], exp_q[bad]);
        end
    endtask

    task automatic set_exp();
        for (int p = 0; p < NPIX; p++) exp_q[p] = qref(int'(vals[p]));
    endtask

    // Present one pixel and hold it until accepted; returns #1 after the accept edge.
    task automatic send(input logic [7:0] v, input logic s);
        int n = 0;
        bus.pix_valid = 1'b1;
        bus.pix_in    = v;
        bus.pix_sof   = s;
        while (!bus.pix_ready && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: pix_ready stuck at %0d, expected 1", bus.pix_ready);
        end else begin
            @(posedge clk); #1;
        end
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
    endtask

    task automatic load(input int first, input int lst, input bit sof_first);
        for (int i = first; i <= lst; i++) send(vals[i], sof_first && i == first);
    endtask

    task automatic consume();
        bus.frame_ready = 1'b1;
        @(posedge clk); #1;
        bus.frame_ready = 1'b0;
    endtask

    initial begin
        tv[0] = '{8'd63,  2'd0};
        tv[1] = '{8'd64,  2'd1};
        tv[2] = '{8'd127, 2'd1};
        tv[3] = '{8'd128, 2'd2};
        tv[4] = '{8'd191, 2'd2};
        tv[5] = '{8'd192, 2'd3};
        tv[6] = '{8'd255, 2'd3};

        bus.pix_in = '0; bus.pix_sof = 1'b0; bus.pix_valid = 1'b0; bus.frame_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_frame_zero", 32'(bus.frame != '0), 0);
        chk("rst_frame_valid", 32'(bus.frame_valid), 0);
        chk("rst_pix_ready", 32'(bus.pix_ready), 1);
        chk("rst_frame_count", 32'(bus.frame_count), 0);
        chk("rst_sof_err", 32'(bus.sof_err), 0);

        // 1: ramp frame, front buffer free
        for (int p = 0; p < NPIX; p++) vals[p] = 8'(p % 256);
        load(0, NPIX-1, 1'b1);
        set_exp();
        chk("t1_frame_valid", 32'(bus.frame_valid), 1);
        chk("t1_pix0", 32'(bus.frame[935:934]), 0);
        chk("t1_pix467", 32'(bus.frame[1:0]), 3);
        chk("t1_count", 32'(bus.frame_count), 1);
        chk_frame("t1_frame");

        // 2: second frame while front is held -> HOLD
        for (int p = 0; p < NPIX; p++) vals[p] = 8'd100;
        load(0, NPIX-1, 1'b1);
        chk("t2_pix_ready_hold", 32'(bus.pix_ready), 0);
        chk_frame("t2_frame_held");
        chk("t2_count_held", 32'(bus.frame_count), 1);
        consume();
        set_exp();
        chk_frame("t2_frame_swapped");
        chk("t2_frame_valid", 32'(bus.frame_valid), 1);
        chk("t2_count", 32'(bus.frame_count), 2);
        chk("t2_pix_ready", 32'(bus.pix_ready), 1);

        // 3: last accept coincides with consumption -> swap without stall
        for (int p = 0; p < NPIX; p++) vals[p] = 8'((p * 7) % 256);
        load(0, NPIX-2, 1'b1);
        bus.frame_ready = 1'b1;
        send(vals[NPIX-1], 1'b0);
        bus.frame_ready = 1'b0;
        set_exp();
        chk("t3_pix_ready", 32'(bus.pix_ready), 1);
        chk("t3_frame_valid", 32'(bus.frame_valid), 1);
        chk("t3_count", 32'(bus.frame_count), 3);
        chk_frame("t3_frame");

        // consumption without new frame clears valid, keeps frame
        consume();
        chk("t3_consumed_valid", 32'(bus.frame_valid), 0);
        chk_frame("t3_frame_kept");

        // 4: SOF resync after 100 pixels
        for (int p = 0; p < NPIX; p++) vals[p] = 8'd50;
        load(0, 99, 1'b1);
        send(8'd255, 1'b1);
        chk("t4_sof_err_pulse", 32'(bus.sof_err), 1);
        @(posedge clk); #1;
        chk("t4_sof_err_clear", 32'(bus.sof_err), 0);
        for (int i = 1; i < NPIX; i++) send(8'd0, 1'b0);
        for (int p = 0; p < NPIX; p++) exp_q[p] = 2'd0;
        exp_q[0] = 2'd3;
        chk("t4_count", 32'(bus.frame_count), 4);
        chk_frame("t4_frame");

        // 5: pixels at index 0 without SOF are dropped
        consume();
        for (int i = 0; i < 5; i++) begin
            send(8'(200 + i), 1'b0);
            chk($sformatf("t5_drop_err%0d", i), 32'(bus.sof_err), 1);
        end
        for (int p = 0; p < NPIX; p++) vals[p] = 8'((p * 3) % 256);
        send(vals[0], 1'b1);
        chk("t5_sof_ok", 32'(bus.sof_err), 0);
        load(1, NPIX-1, 1'b0);
        set_exp();
        chk("t5_count", 32'(bus.frame_count), 5);
        chk_frame("t5_frame");

        // 6: threshold table
        consume();
        for (int p = 0; p < NPIX; p++) vals[p] = 8'd0;
        for (int i = 0; i < 7; i++) vals[i] = tv[i].pix;
        load(0, NPIX-1, 1'b1);
        for (int i = 0; i < 7; i++)
            chk($sformatf("t6_thr_%0d", tv[i].pix), 32'(bus.frame[2*(NPIX-1-i) +: 2]), 32'(tv[i].q));
        chk("t6_count", 32'(bus.frame_count), 6);

        // mid-frame reset
        for (int p = 0; p < 50; p++) send(8'd255, p == 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_rst_frame_zero", 32'(bus.frame != '0), 0);
        chk("t6_rst_valid", 32'(bus.frame_valid), 0);
        chk("t6_rst_count", 32'(bus.frame_count), 0);
        chk("t6_rst_ready", 32'(bus.pix_ready), 1);
        for (int p = 0; p < NPIX; p++) vals[p] = 8'd130;
        load(0, NPIX-1, 1'b1);
        set_exp();
        chk("t6_reload_valid", 32'(bus.frame_valid), 1);
        chk("t6_reload_count", 32'(bus.frame_count), 1);
        chk_frame("t6_reload_frame");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/twobit_frame_loader.md
Name: twobit_frame_loader

Overview:
Upstream feeder for the 26x18 two-bit contour mesh. It accepts a raster stream of 8-bit grayscale pixels, quantizes each pixel to 2 bits, and assembles 468 pixels in a back buffer. Completed frames are swapped into a front buffer that drives the mesh's 936-bit parallel pixel input. Double buffering lets the next frame stream in while the mesh works on the current one.

Parameters:
COLS, 26, pixels per row
ROWS, 18, rows per frame (COLS*ROWS = 468 = NPIX)
TH1, 8'd64, quantization threshold 0/1
TH2, 8'd128, quantization threshold 1/2
TH3, 8'd192, quantization threshold 2/3
REQUIRE_SOF, 1, drop pixels at index 0 that are not marked pix_sof

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-high reset
pix_in  in  8  grayscale pixel
pix_sof  in  1  marks first pixel of a frame
pix_valid  in  1  pixel qualifier
pix_ready  out  1  loader can accept a pixel
frame  out  2*NPIX  front-buffer frame, mesh input format
frame_valid  out  1  front buffer holds an unconsumed frame
frame_ready  in  1  consumer takes the frame
frame_count  out  8  completed frames swapped to front, wraps at 255
sof_err  out  1  one-cycle pulse on resync or dropped pixel

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values: frame=0, frame_valid=0, pix_ready=1, frame_count=0, sof_err=0, write index=0, state=FILL. Reset mid-frame discards the partial back buffer. Reset also clears the front buffer.
- Accept condition: a pixel is accepted when pix_valid & pix_ready at the clock edge.
- Quantization (combinational, before write):
  - q=0 if pix<TH1
  - q=1 if pix<TH2
  - q=2 if pix<TH3
  - q=3 otherwise
  - Comparisons are unsigned 8-bit.
- Packing: raster index p (row-major, p = row*COLS + col, 0..467) is stored at frame[2*(NPIX-1-p)+1 : 2*(NPIX-1-p)]. Pixel 0 therefore occupies frame[935:934], and pixel 467 occupies frame[1:0].
- Write index: a single counter idx (9 bits) counts 0..NPIX-1. Row and column are not tracked separately.
- States:
  - FILL: pix_ready=1; accepted pixels are written to back[idx].
  - HOLD: back buffer is full and the front buffer is occupied; pix_ready=0.
- Frame completion (accept at idx=NPIX-1 in cycle N):
  - If frame_valid=0, or frame_valid & frame_ready in cycle N: at N+1 the front takes the back contents, frame_valid=1, frame_count+1, idx=0, and the state stays FILL. There is no stall.
  - Otherwise: enter HOLD at N+1.
- HOLD exit: on the first cycle with frame_valid & frame_ready, the next edge performs the swap, sets frame_valid=1, increments frame_count, and returns to FILL with pix_ready=1.
- Consumption without a new frame: frame_valid & frame_ready clears frame_valid. The frame output keeps its last value, because the mesh samples continuously.
- SOF handling:
  - pix_sof accepted at idx=0: normal.
  - pix_sof accepted at idx≠0: the partial frame is abandoned, the pixel is written as index 0, idx becomes 1, and sof_err pulses.
  - With REQUIRE_SOF=1, a pixel accepted at idx=0 without pix_sof is consumed and discarded; idx stays 0 and sof_err pulses.
- Latency: last pixel accepted to frame/frame_valid updated is 1 cycle when the front buffer is free.
- frame changes only on a swap edge or on rst.

Decomposition:
- Shared package holds:
  - constants COLS, ROWS, NPIX=COLS*ROWS, PIXW=2
  - a function pix_slice_lsb(p) returning 2*(NPIX-1-p), so the mesh and the loader agree on packing
  - a state enum {FILL, HOLD}
- One sub-module is natural: twobit_quantizer. It is a combinational 8-bit to 2-bit threshold compare, parameterized by TH1..TH3. It is reused by later stream stages.

Test Plan:
1. Reset, then stream 468 pixels with value p%256 (sof on the first) and frame_ready=0. Required: frame_valid=1 one cycle after the last accept; frame[935:934]=0 (p=0); frame[1:0]=q(467%256=211)=3; frame_count=1.
2. With a frame held unconsumed, stream a second full frame of constant 100. Required: pix_ready=0 after the last accept and frame unchanged. Then pulse frame_ready: swap on the next edge, every pixel equals 1, frame_count=2, pix_ready=1.
3. Stream a frame whose last accept coincides with frame_valid & frame_ready. Required: swap at N+1 with no cycle of pix_ready=0.
4. After 100 pixels, assert pix_sof on a pixel of value 255. Required: sof_err pulses one cycle. After 467 more pixels of value 0, the frame shows pixel 0=3 and all others 0.
5. With REQUIRE_SOF=1, send 5 pixels without sof at idx 0, then a proper frame. Required: five sof_err pulses, and the frame contains only the proper frame data.
6. Thresholds: pixel values 63, 64, 127, 128, 191, 192, 255 map to 0, 1, 1, 2, 2, 3, 3. Assert rst mid-frame: frame=0, frame_valid=0, frame_count=0, and the next frame loads cleanly.
